// File: rtl/outlier_pkg.sv
// Shared types and width helpers for the outlier-aware dot-product engine.
// No logic, no latency.
// No handshake of its own.
package outlier_pkg;

  // Engine sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INLIER  = 2'd1,
    OUTLIER = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Exact signed dot-product width: two full products plus growth for DIMM terms
  function automatic int psum_w(input int dimm, input int data_w);
    return 2 * data_w + $clog2(dimm);
  endfunction

  // Width able to hold a count from 0 to dimm inclusive
  function automatic int cnt_w(input int dimm);
    return $clog2(dimm + 1);
  endfunction

  // Lane index width, never narrower than one bit
  function automatic int idx_w(input int dimm);
    return (dimm > 1) ? $clog2(dimm) : 1;
  endfunction

endpackage

// File: rtl/lane_priority_picker.sv
// Picks up to NUM_LR set mask bits, lowest index first, and returns the mask without them.
// Purely combinational, zero latency.
// No handshake; the caller decides when to consume the selection.
module lane_priority_picker
  import outlier_pkg::*;
#(
  parameter int DIMM   = 64,
  parameter int NUM_LR = 4,
  parameter int IDX_W  = idx_w(DIMM)
) (
  input  logic [DIMM-1:0]               mask,
  output logic [NUM_LR-1:0][IDX_W-1:0]  idx,
  output logic [NUM_LR-1:0]             sel,
  output logic [DIMM-1:0]               mask_left
);

  logic [DIMM-1:0] rem;
  logic            found;

  // Chain of NUM_LR find-first-set stages, each removing the bit it claimed
  always_comb begin
    rem   = mask;
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_LR; k++) begin
      found = 1'b0;
      for (int i = 0; i < DIMM; i++) begin
        if (!found && rem[i]) begin
          idx[k] = IDX_W'(i);
          sel[k] = 1'b1;
          rem[i] = 1'b0;
          found  = 1'b1;
        end
      end
    end
    mask_left = rem;
  end

endmodule

// File: rtl/outlier_dot_engine.sv
// Exact signed dot product: narrow multipliers for inlier lanes, NUM_LR wide ones for outliers.
// Result valid 2 + ceil(outliers/NUM_LR) cycles after the operand transfer.
// One job in flight; in_ready low until the result is taken, result held while out_ready is low.
module outlier_dot_engine
  import outlier_pkg::*;
#(
  parameter  int DIMM     = 64,
  parameter  int NUM_LR   = 4,
  parameter  int DATA_W   = 16,
  parameter  int INLIER_W = 8,
  localparam int PSUM_W   = psum_w(DIMM, DATA_W),
  localparam int CNT_W    = cnt_w(DIMM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIMM-1:0][DATA_W-1:0]  arrayA,
  input  logic [DIMM-1:0][DATA_W-1:0]  arrayW,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [PSUM_W-1:0]     psum,
  output logic [CNT_W-1:0]             outlier_cnt
);

  localparam int IDX_W = idx_w(DIMM);
  localparam logic signed [DATA_W-1:0] IN_MAX = DATA_W'((1 << (INLIER_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] IN_MIN = DATA_W'(-(1 << (INLIER_W - 1)));

  state_t                         state;
  logic [DIMM-1:0][DATA_W-1:0]    a_reg, w_reg;
  logic [DIMM-1:0]                mask, lane_out, mask_left;
  logic signed [PSUM_W-1:0]       acc, inlier_sum, pick_sum;
  logic [CNT_W-1:0]               lane_cnt;
  logic [NUM_LR-1:0][IDX_W-1:0]   pick_idx;
  logic [NUM_LR-1:0]              pick_sel;

  logic signed [DATA_W-1:0]       la, lw, pa, pw;
  logic signed [INLIER_W-1:0]     sa, sw;
  logic signed [2*INLIER_W-1:0]   sp;
  logic signed [2*DATA_W-1:0]     pp;

  // Classify lanes and sum inlier products through INLIER_W-wide multipliers
  always_comb begin
    lane_out   = '0;
    lane_cnt   = '0;
    inlier_sum = '0;
    la = '0; lw = '0; sa = '0; sw = '0; sp = '0;
    for (int i = 0; i < DIMM; i++) begin
      la = a_reg[i];
      lw = w_reg[i];
      lane_out[i] = (la > IN_MAX) || (la < IN_MIN) || (lw > IN_MAX) || (lw < IN_MIN);
      sa = la[INLIER_W-1:0];
      sw = lw[INLIER_W-1:0];
      sp = sa * sw;
      if (!lane_out[i]) inlier_sum = inlier_sum + PSUM_W'(sp);
      lane_cnt = lane_cnt + CNT_W'(lane_out[i]);
    end
  end

  lane_priority_picker #(
    .DIMM   (DIMM),
    .NUM_LR (NUM_LR),
    .IDX_W  (IDX_W)
  ) u_picker (
    .mask      (mask),
    .idx       (pick_idx),
    .sel       (pick_sel),
    .mask_left (mask_left)
  );

  // Full-width products of this pass's picked outlier lanes
  always_comb begin
    pick_sum = '0;
    pa = '0; pw = '0; pp = '0;
    for (int k = 0; k < NUM_LR; k++) begin
      pa = a_reg[pick_idx[k]];
      pw = w_reg[pick_idx[k]];
      pp = pa * pw;
      if (pick_sel[k]) pick_sum = pick_sum + PSUM_W'(pp);
    end
  end

  // Job sequencer: capture, inlier pass, outlier passes, hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      w_reg       <= '0;
      mask        <= '0;
      acc         <= '0;
      psum        <= '0;
      outlier_cnt <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= arrayA;
            w_reg    <= arrayW;
            in_ready <= 1'b0;
            state    <= INLIER;
          end
        end
        INLIER: begin
          acc         <= inlier_sum;
          mask        <= lane_out;
          outlier_cnt <= lane_cnt;
          if (lane_out == '0) begin
            psum      <= inlier_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            state <= OUTLIER;
          end
        end
        OUTLIER: begin
          acc  <= acc + pick_sum;
          mask <= mask_left;
          if (mask_left == '0) begin
            psum      <= acc + pick_sum;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_outlier_dot_engine.sv
// Randomized and directed bench for outlier_dot_engine against a plain-arithmetic model.
// Latency measured in clock edges from the operand transfer edge.
// Exercises result backpressure, ignored input traffic and mid-job reset.
module tb_outlier_dot_engine;

  localparam int DIMM     = 64;
  localparam int NUM_LR   = 4;
  localparam int DATA_W   = 16;
  localparam int INLIER_W = 8;
  localparam int PSUM_W   = 2 * DATA_W + $clog2(DIMM);
  localparam int CNT_W    = $clog2(DIMM + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DIMM-1:0][DATA_W-1:0] arrayA = '0;
  logic [DIMM-1:0][DATA_W-1:0] arrayW = '0;
  logic signed [PSUM_W-1:0] psum;
  logic [CNT_W-1:0] outlier_cnt;

  int errors = 0;
  int checks = 0;
  int ta[DIMM];
  int tw[DIMM];

  always #5 clk = ~clk;

  outlier_dot_engine #(
    .DIMM     (DIMM),
    .NUM_LR   (NUM_LR),
    .DATA_W   (DATA_W),
    .INLIER_W (INLIER_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .arrayA      (arrayA),
    .arrayW      (arrayW),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .psum        (psum),
    .outlier_cnt (outlier_cnt)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit out_of_range(input int v);
    return (v < -(1 << (INLIER_W - 1))) || (v > (1 << (INLIER_W - 1)) - 1);
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < DIMM; i++) begin
      ta[i] = 0;
      tw[i] = 0;
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < DIMM; i++) begin
      arrayA[i] = DATA_W'($urandom);
      arrayW[i] = DATA_W'($urandom);
    end
  endtask

  // Present ta/tw, wait for the result, check it, optionally stall, then take it.
  task automatic run_job(input string tag, input int stall);
    longint exp_sum = 0;
    int     k = 0;
    int     lat = 0;
    bit     seen = 1'b0;
    for (int i = 0; i < DIMM; i++) begin
      exp_sum += longint'(ta[i]) * longint'(tw[i]);
      if (out_of_range(ta[i]) || out_of_range(tw[i])) k++;
    end
    @(negedge clk);
    check({tag, "/in_ready_idle"}, longint'(in_ready), 1);
    for (int i = 0; i < DIMM; i++) begin
      arrayA[i] = DATA_W'(ta[i]);
      arrayW[i] = DATA_W'(tw[i]);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = c;
      end
      scramble_inputs();
      in_valid = 1'($urandom_range(0, 1));
    end
    check({tag, "/result_seen"}, longint'(seen), 1);
    check({tag, "/latency"}, lat, 2 + (k + NUM_LR - 1) / NUM_LR);
    check({tag, "/psum"}, longint'(psum), exp_sum);
    check({tag, "/outlier_cnt"}, longint'(outlier_cnt), k);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(posedge clk);
      @(negedge clk);
      check({tag, "/stall_psum"}, longint'(psum), exp_sum);
      check({tag, "/stall_in_ready"}, longint'(in_ready), 0);
      check({tag, "/stall_out_valid"}, longint'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "/in_ready_after"}, longint'(in_ready), 1);
    check({tag, "/out_valid_after"}, longint'(out_valid), 0);
  endtask

  // Start a three-pass job and pull reset while it is in its outlier passes.
  task automatic reset_mid_job();
    bit any_valid = 1'b0;
    clear_lanes();
    for (int i = 0; i < 9; i++) begin
      ta[i] = -32768;
      tw[i] = -32768;
    end
    @(negedge clk);
    for (int i = 0; i < DIMM; i++) begin
      arrayA[i] = DATA_W'(ta[i]);
      arrayW[i] = DATA_W'(tw[i]);
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst/psum", longint'(psum), 0);
    check("rst/outlier_cnt", longint'(outlier_cnt), 0);
    check("rst/out_valid", longint'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst/in_ready_release", longint'(in_ready), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    check("rst/no_result", longint'(any_valid), 0);
    check("rst/in_ready_idle", longint'(in_ready), 1);
  endtask

  initial begin
    int p;
    repeat (3) @(posedge clk);
    #1;
    check("reset/in_ready", longint'(in_ready), 1);
    check("reset/out_valid", longint'(out_valid), 0);
    check("reset/psum", longint'(psum), 0);
    check("reset/outlier_cnt", longint'(outlier_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // all lanes small
    for (int i = 0; i < DIMM; i++) begin
      ta[i] = 1;
      tw[i] = 2;
    end
    run_job("ones", 0);

    // one outlier pass, also used for backpressure
    clear_lanes();
    for (int i = 0; i < 4; i++) begin
      ta[i] = 1000;
      tw[i] = 3;
    end
    run_job("four_out", 0);
    run_job("backpressure", 5);

    // inlier range edges
    clear_lanes();
    ta[0] = 127;  tw[0] = 1;
    ta[1] = -128; tw[1] = 1;
    ta[2] = 128;  tw[2] = 1;
    ta[3] = -129; tw[3] = 1;
    run_job("edges", 0);

    // three outlier passes at the most negative operand
    clear_lanes();
    for (int i = 0; i < 9; i++) begin
      ta[i] = -32768;
      tw[i] = -32768;
    end
    run_job("nine_out", 1);

    reset_mid_job();

    // worst-case magnitude: every lane an outlier
    for (int i = 0; i < DIMM; i++) begin
      ta[i] = -32768;
      tw[i] = -32768;
    end
    run_job("all_out", 0);

    // randomized mixes with varying outlier density
    for (int j = 0; j < 30; j++) begin
      p = $urandom_range(0, 10);
      for (int i = 0; i < DIMM; i++) begin
        if (int'($urandom_range(0, 9)) < p) begin
          ta[i] = int'($urandom_range(0, 65535)) - 32768;
          tw[i] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          ta[i] = int'($urandom_range(0, 255)) - 128;
          tw[i] = int'($urandom_range(0, 255)) - 128;
        end
      end
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
